tl_burst_rr_scheduler: RTL

//  Burst-aware round-robin scheduler for one shared TileLink request-type channel (A or C).

---
 rtl/tl_burst_rr_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tl_burst_rr_scheduler.sv
// Burst-aware round-robin scheduler for one shared TileLink A/C channel.
// Holds a grant from the first visible beat until the final beat of that message fires.
module tl_burst_rr_scheduler #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned SizeWidth = 3,
  parameter int unsigned MaxSize   = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq-1:0]           req_data_i,
  input  logic [NumReq*SizeWidth-1:0] req_size_i,
  output logic [NumReq-1:0]           req_ready_o,
  output logic                        dev_valid_o,
  input  logic                        dev_ready_i,
  output logic [NumReq-1:0]           sel_o,
  output logic                        last_o,
  output logic                        busy_o
);

  localparam int unsigned NonBurstSize = $clog2(DataWidth / 8);
  localparam int unsigned MaxBeats     = (MaxSize > NonBurstSize) ?
                                         (1 << (MaxSize - NonBurstSize)) : 1;
  localparam int unsigned BeatW        = $clog2(MaxBeats + 1);
  localparam int unsigned IdxW         = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  // Oversized requests saturate to the MaxSize burst length.
  function automatic logic [BeatW-1:0] burst_len(input logic data,
                                                 input logic [SizeWidth-1:0] size);
    int unsigned s;
    s = 32'(size);
    if (s > MaxSize) s = MaxSize;
    if (data && (s > NonBurstSize)) return BeatW'(32'(1) << (s - NonBurstSize));
    return BeatW'(1);
  endfunction

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    if (32'(idx) == NumReq - 1) return '0;
    return idx + IdxW'(1);
  endfunction

  state_e           r_state;
  logic [IdxW-1:0]  r_idx;
  logic [IdxW-1:0]  r_prio;
  logic [BeatW-1:0] r_beats;

  logic             w_any;
  logic [IdxW-1:0]  w_pick;
  logic [IdxW-1:0]  w_idx;
  logic [BeatW-1:0] w_len;
  logic             w_fire;

  assign w_any  = |req_valid_i;
  assign busy_o = (r_state == StLocked);

  // Scan from the farthest offset down so the nearest valid at/after r_prio wins.
  always_comb begin
    int unsigned t;
    t      = 0;
    w_pick = r_prio;
    for (int unsigned k = NumReq; k > 0; k--) begin
      t = 32'(r_prio) + k - 1;
      if (t >= NumReq) t = t - NumReq;
      if (req_valid_i[IdxW'(t)]) w_pick = IdxW'(t);
    end
  end

  assign w_idx = (r_state == StLocked) ? r_idx : w_pick;
  assign w_len = burst_len(req_data_i[w_idx], req_size_i[w_idx*SizeWidth +: SizeWidth]);

  always_comb begin
    sel_o       = '0;
    req_ready_o = '0;
    dev_valid_o = 1'b0;
    last_o      = 1'b0;
    w_fire      = 1'b0;
    unique case (r_state)
      StIdle: begin
        sel_o[w_pick]       = w_any;
        req_ready_o[w_pick] = w_any & dev_ready_i;
        dev_valid_o         = w_any;
        w_fire              = w_any & dev_ready_i;
        last_o              = w_fire && (w_len == BeatW'(1));
      end
      StLocked: begin
        sel_o[r_idx]       = 1'b1;
        req_ready_o[r_idx] = dev_ready_i;
        dev_valid_o        = req_valid_i[r_idx];
        w_fire             = req_valid_i[r_idx] & dev_ready_i;
        last_o             = w_fire && ((r_beats == BeatW'(1)) ||
                                        ((r_beats == '0) && (w_len == BeatW'(1))));
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_prio  <= '0;
      r_beats <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            if (last_o) begin
              r_prio <= next_idx(w_pick);
            end else begin
              // A stalled first beat locks too, so the visible grant never moves.
              r_state <= StLocked;
              r_idx   <= w_pick;
              r_beats <= w_fire ? (w_len - BeatW'(1)) : w_len;
            end
          end
        end
        StLocked: begin
          if (w_fire) begin
            if (last_o) begin
              r_state <= StIdle;
              r_prio  <= next_idx(r_idx);
              r_beats <= '0;
            end else begin
              r_beats <= ((r_beats == '0) ? w_len : r_beats) - BeatW'(1);
            end
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NumReq; g++) begin : g_size_chk
    a_size_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      req_valid_i[g] |-> (32'(req_size_i[g*SizeWidth +: SizeWidth]) <= MaxSize));
  end

endmodule
